// File: rtl/decode_arbiter_if.sv
// Request/response bundle between the requesters, decode_arbiter and the shared decode_fp.
// slave is the arbiter side; master is the environment (requesters plus decoder).
interface decode_arbiter_if;
   logic [3:0]  req;
   logic [63:0] fp_bus;
   logic [3:0]  rsp_valid;
   logic [3:0]  rsp_d1;
   logic [3:0]  rsp_d2;
   logic        rsp_err;
   logic        busy;
   logic        dec_start;
   logic [15:0] dec_fp;
   logic        dec_ack;
   logic        dec_done;
   logic [3:0]  dec_d1;
   logic [3:0]  dec_d2;

   modport slave (
      input  req, fp_bus, dec_done, dec_d1, dec_d2,
      output rsp_valid, rsp_d1, rsp_d2, rsp_err, busy, dec_start, dec_fp, dec_ack
   );

   modport master (
      output req, fp_bus, dec_done, dec_d1, dec_d2,
      input  rsp_valid, rsp_d1, rsp_d2, rsp_err, busy, dec_start, dec_fp, dec_ack
   );
endinterface

// File: rtl/decode_arbiter.sv
// Round-robin arbiter sharing one decode_fp among four requesters, with decoder Start/Ack
// handshake, hung-decoder timeout and one-cycle response strobe. All outputs registered.
module decode_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input logic             clk,
   input logic             reset_n,
   decode_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StReply} state_e;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [1:0]  last_grant_q, last_grant_d;
   logic [1:0]  grant_q, grant_d;
   logic        mask_q, mask_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] dec_fp_q, dec_fp_d;
   logic        dec_start_q, dec_start_d;
   logic        dec_ack_q, dec_ack_d;
   logic [3:0]  rsp_valid_q, rsp_valid_d;
   logic [3:0]  rsp_d1_q, rsp_d1_d;
   logic [3:0]  rsp_d2_q, rsp_d2_d;
   logic        rsp_err_q, rsp_err_d;
   logic        busy_q, busy_d;

   logic [3:0]  eligible;
   logic        found;
   logic [1:0]  pick;

   // The requester just served is masked for exactly one IDLE cycle after REPLY.
   always_comb begin
      eligible = bus.req & ~(mask_q ? (4'b0001 << last_grant_q) : 4'b0000);
      found    = 1'b0;
      pick     = last_grant_q;
      for (int k = 1; k <= 4; k++) begin
         if (!found && eligible[last_grant_q + 2'(k)]) begin
            found = 1'b1;
            pick  = last_grant_q + 2'(k);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      mask_d       = mask_q;
      cnt_d        = cnt_q;
      dec_fp_d     = dec_fp_q;
      dec_start_d  = dec_start_q;
      dec_ack_d    = dec_ack_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_d1_d     = rsp_d1_q;
      rsp_d2_d     = rsp_d2_q;
      rsp_err_d    = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            mask_d = 1'b0;
            if (found) begin
               grant_d     = pick;
               dec_fp_d    = bus.fp_bus[{pick, 4'b0000} +: 16];
               dec_start_d = 1'b1;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            dec_start_d = 1'b0;
            cnt_d       = 8'd0;
            state_d     = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + 8'd1;
            // Done wins over a timeout landing in the same cycle.
            if (bus.dec_done) begin
               rsp_d1_d    = bus.dec_d1;
               rsp_d2_d    = bus.dec_d2;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 4'b0001 << grant_q;
               dec_ack_d   = 1'b1;
               state_d     = StReply;
            end else if (cnt_q == CntLast) begin
               rsp_d1_d    = 4'd15;
               rsp_d2_d    = 4'd15;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 4'b0001 << grant_q;
               dec_ack_d   = 1'b1;
               state_d     = StReply;
            end
         end
         StReply: begin
            rsp_valid_d  = 4'b0000;
            dec_ack_d    = 1'b0;
            rsp_err_d    = 1'b0;
            last_grant_d = grant_q;
            mask_d       = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         last_grant_q <= 2'd3;
         grant_q      <= 2'd0;
         mask_q       <= 1'b0;
         cnt_q        <= 8'd0;
         dec_fp_q     <= 16'd0;
         dec_start_q  <= 1'b0;
         dec_ack_q    <= 1'b0;
         rsp_valid_q  <= 4'd0;
         rsp_d1_q     <= 4'd0;
         rsp_d2_q     <= 4'd0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         mask_q       <= mask_d;
         cnt_q        <= cnt_d;
         dec_fp_q     <= dec_fp_d;
         dec_start_q  <= dec_start_d;
         dec_ack_q    <= dec_ack_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_d1_q     <= rsp_d1_d;
         rsp_d2_q     <= rsp_d2_d;
         rsp_err_q    <= rsp_err_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_d1    = rsp_d1_q;
   assign bus.rsp_d2    = rsp_d2_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = busy_q;
   assign bus.dec_start = dec_start_q;
   assign bus.dec_fp    = dec_fp_q;
   assign bus.dec_ack   = dec_ack_q;

endmodule

// File: tb/tb_decode_arbiter.sv
// Bench for decode_arbiter: behavioural decode_fp stub, vector table, directed corner cases
// and randomized rounds checked against a transaction-level round-robin model.
module tb_decode_arbiter;

   logic clk;
   logic reset_n;
   decode_arbiter_if bus ();

   decode_arbiter #(.TIMEOUT(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Decoder digits: value in [0,1) -> tenths and hundredths rounded down to 0/5, else 15/15.
   function automatic logic [7:0] ref_digits(input logic [15:0] fp);
      int unsigned e, m, h;
      e = 32'(fp[14:10]);
      m = 32'(fp[9:0]);
      if (fp[15] || e >= 15) return 8'hFF;
      if (e == 0) h = (m * 100) >> 24;
      else        h = ((1024 + m) * 100) >> (25 - e);
      return {4'(h / 10), ((h % 10) >= 5) ? 4'd5 : 4'd0};
   endfunction

   // Decoder stub: Done after 3 edges past Start (2 if out of range), held until Ack.
   int   dec_lat_override;
   int   dec_cnt;
   logic dec_running;
   always @(posedge clk) begin
      if (!reset_n) begin
         bus.dec_done <= 1'b0;
         dec_running  <= 1'b0;
         dec_cnt      <= 0;
      end else if (bus.dec_ack) begin
         bus.dec_done <= 1'b0;
         dec_running  <= 1'b0;
      end else if (dec_running) begin
         if (dec_cnt == 0) begin
            bus.dec_done <= 1'b1;
            dec_running  <= 1'b0;
         end else begin
            dec_cnt <= dec_cnt - 1;
         end
      end else if (bus.dec_start && !bus.dec_done) begin
         dec_running <= 1'b1;
         if (dec_lat_override != 0) dec_cnt <= dec_lat_override - 1;
         else dec_cnt <= (ref_digits(bus.dec_fp) == 8'hFF) ? 1 : 2;
         {bus.dec_d1, bus.dec_d2} <= ref_digits(bus.dec_fp);
      end
   end

   int   start_bad, ack_bad, onehot_bad;
   logic start_prev;
   initial begin
      start_bad = 0; ack_bad = 0; onehot_bad = 0; start_prev = 1'b0;
   end
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.dec_start && start_prev) start_bad++;
         if (bus.dec_ack !== (bus.rsp_valid != 4'd0)) ack_bad++;
         if (bus.rsp_valid != 4'd0 && !$onehot(bus.rsp_valid)) onehot_bad++;
      end
      start_prev = bus.dec_start;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic set_fp(input int i, input logic [15:0] v);
      bus.fp_bus[16*i +: 16] = v;
   endtask

   task automatic wait_rsp(input int budget, output int cycles, output logic got);
      got = 1'b0;
      cycles = 0;
      while (cycles < budget && !got) begin
         @(negedge clk);
         cycles++;
         if (bus.rsp_valid != 4'd0) got = 1'b1;
      end
   endtask

   // lat < 0 skips the latency comparison; cyc returns cycles waited.
   task automatic expect_rsp(input string tag, input logic [3:0] valid, input logic [3:0] d1,
                             input logic [3:0] d2, input logic err, input int lat,
                             output int cyc);
      logic got;
      wait_rsp(40, cyc, got);
      check({tag, ".seen"}, 32'(got), 32'd1);
      if (got) begin
         check({tag, ".valid"}, 32'(bus.rsp_valid), 32'(valid));
         check({tag, ".d1"}, 32'(bus.rsp_d1), 32'(d1));
         check({tag, ".d2"}, 32'(bus.rsp_d2), 32'(d2));
         check({tag, ".err"}, 32'(bus.rsp_err), 32'(err));
         check({tag, ".ack"}, 32'(bus.dec_ack), 32'd1);
         if (lat >= 0) check({tag, ".lat"}, 32'(cyc), 32'(lat));
      end
   endtask

   typedef struct {
      int          slot;
      logic [15:0] fp;
      logic [3:0]  exp_valid;
      logic [3:0]  exp_d1;
      logic [3:0]  exp_d2;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t        vecs[7];
   int          cyc;
   int          model_last;
   int          served;
   logic [3:0]  pat;
   logic [15:0] fpv;
   logic [15:0] rf[4];
   logic [7:0]  dg;

   initial begin
      vecs[0] = '{0, 16'h3A00, 4'b0001, 4'd7,  4'd5,  1'b0, 6};
      vecs[1] = '{1, 16'h3800, 4'b0010, 4'd5,  4'd0,  1'b0, 6};
      vecs[2] = '{2, 16'h3C00, 4'b0100, 4'd15, 4'd15, 1'b0, 5};
      vecs[3] = '{3, 16'h3400, 4'b1000, 4'd2,  4'd5,  1'b0, 6};
      vecs[4] = '{0, 16'h0000, 4'b0001, 4'd0,  4'd0,  1'b0, 6};
      vecs[5] = '{2, 16'hBA00, 4'b0100, 4'd15, 4'd15, 1'b0, 5};
      vecs[6] = '{3, 16'h3BFF, 4'b1000, 4'd9,  4'd5,  1'b0, 6};

      n_pass = 0; n_total = 0;
      reset_n = 1'b0; bus.req = 4'd0; bus.fp_bus = 64'd0; dec_lat_override = 0;
      repeat (3) @(negedge clk);
      check("reset.valid", 32'(bus.rsp_valid), 32'd0);
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.start", 32'(bus.dec_start), 32'd0);
      check("reset.ack", 32'(bus.dec_ack), 32'd0);
      check("reset.fp", 32'(bus.dec_fp), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // All four requesting: strict order 0..3, one mask cycle between transactions.
      set_fp(0, 16'h3800); set_fp(1, 16'h3400); set_fp(2, 16'h3C00); set_fp(3, 16'h3A00);
      bus.req = 4'hF;
      expect_rsp("rr0", 4'b0001, 4'd5,  4'd0,  1'b0, 6, cyc);
      expect_rsp("rr1", 4'b0010, 4'd2,  4'd5,  1'b0, 7, cyc);
      expect_rsp("rr2", 4'b0100, 4'd15, 4'd15, 1'b0, 6, cyc);
      expect_rsp("rr3", 4'b1000, 4'd7,  4'd5,  1'b0, 7, cyc);
      bus.req = 4'd0;

      for (int i = 0; i < 7; i++) begin
         repeat (2) @(negedge clk);
         set_fp(vecs[i].slot, vecs[i].fp);
         bus.req = 4'b0001 << vecs[i].slot;
         @(negedge clk);
         check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'd1);
         expect_rsp($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_d1, vecs[i].exp_d2,
                    vecs[i].exp_err, vecs[i].exp_lat - 1, cyc);
         bus.req = 4'd0;
      end

      // Requester 2 keeps requesting: it must sit out the mask cycle.
      repeat (2) @(negedge clk);
      set_fp(2, 16'h3800); set_fp(0, 16'h3400);
      bus.req = 4'b0100;
      expect_rsp("mask.a", 4'b0100, 4'd5, 4'd0, 1'b0, 6, cyc);
      @(negedge clk);
      check("mask.idle", 32'(bus.busy), 32'd0);
      bus.req = 4'b0101;
      expect_rsp("mask.b", 4'b0001, 4'd2, 4'd5, 1'b0, 6, cyc);
      bus.req = 4'b0100;
      expect_rsp("mask.c", 4'b0100, 4'd5, 4'd0, 1'b0, 7, cyc);
      bus.req = 4'd0;

      // Hung decoder, Done on the last WAIT cycle, Done one cycle too late.
      repeat (2) @(negedge clk);
      dec_lat_override = 1000; set_fp(1, 16'h3A00); bus.req = 4'b0010;
      expect_rsp("tmo", 4'b0010, 4'd15, 4'd15, 1'b1, 10, cyc);
      bus.req = 4'd0;
      @(negedge clk);
      check("tmo.err_clear", 32'(bus.rsp_err), 32'd0);
      check("tmo.d1_hold", 32'(bus.rsp_d1), 32'd15);
      repeat (2) @(negedge clk);
      dec_lat_override = 7; set_fp(3, 16'h3A00); bus.req = 4'b1000;
      expect_rsp("tie", 4'b1000, 4'd7, 4'd5, 1'b0, 10, cyc);
      bus.req = 4'd0;
      repeat (2) @(negedge clk);
      dec_lat_override = 8; set_fp(0, 16'h3400); bus.req = 4'b0001;
      expect_rsp("late", 4'b0001, 4'd15, 4'd15, 1'b1, 10, cyc);
      bus.req = 4'd0; dec_lat_override = 0;

      // Reset mid-WAIT abandons the transaction and restores requester 0 priority.
      repeat (2) @(negedge clk);
      set_fp(2, 16'h3800); bus.req = 4'b0100;
      expect_rsp("pre", 4'b0100, 4'd5, 4'd0, 1'b0, 6, cyc);
      bus.req = 4'd0;
      repeat (2) @(negedge clk);
      dec_lat_override = 1000; set_fp(1, 16'h3A00); bus.req = 4'b0010;
      repeat (3) @(negedge clk);
      check("rst.in_wait", 32'(bus.busy), 32'd1);
      reset_n = 1'b0; bus.req = 4'd0;
      @(negedge clk);
      check("rst.valid", 32'(bus.rsp_valid), 32'd0);
      check("rst.busy", 32'(bus.busy), 32'd0);
      check("rst.fp", 32'(bus.dec_fp), 32'd0);
      check("rst.d1", 32'(bus.rsp_d1), 32'd0);
      check("rst.d2", 32'(bus.rsp_d2), 32'd0);
      reset_n = 1'b1; dec_lat_override = 0;
      set_fp(0, 16'h3400); set_fp(3, 16'h3800); bus.req = 4'b1001;
      expect_rsp("rst.next", 4'b0001, 4'd2, 4'd5, 1'b0, 6, cyc);
      bus.req = 4'b1000;
      expect_rsp("rst.then", 4'b1000, 4'd5, 4'd0, 1'b0, 7, cyc);
      bus.req = 4'd0;

      // Random rounds: each pattern is served once, in rotation after the last grantee.
      model_last = 3;
      for (int r = 0; r < 30; r++) begin
         @(negedge clk);
         pat = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) == 0) fpv = 16'($urandom);
            else fpv = {1'b0, 5'($urandom_range(0, 14)), 10'($urandom)};
            rf[i] = fpv;
            if (pat[i]) set_fp(i, fpv);
         end
         bus.req = pat;
         served = model_last;
         for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (model_last + k) % 4;
            if (pat[idx]) begin
               dg = ref_digits(rf[idx]);
               expect_rsp($sformatf("rnd%0d.%0d", r, idx), 4'b0001 << idx, dg[7:4], dg[3:0],
                          1'b0, -1, cyc);
               bus.req[idx] = 1'b0;
               served = idx;
            end
         end
         model_last = served;
      end

      repeat (3) @(negedge clk);
      check("mon.start_width", 32'(start_bad), 32'd0);
      check("mon.ack_align", 32'(ack_bad), 32'd0);
      check("mon.onehot", 32'(onehot_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/decode_arbiter.md
# decode_arbiter

Round-robin scheduler that shares one `decode_fp` half-precision-to-decimal-digit decoder among four requesters, such as the value and policy display paths of the MDP core. It accepts level requests carrying a 16-bit FP value and grants one requester at a time. It drives the decoder's Start/Ack handshake, watches for a hung decoder with a timeout, and returns the two decoded digits to the granted requester as a one-cycle response pulse.

## Interface
- `TIMEOUT`, 64: max cycles spent in WAIT before forced error completion; legal range 1..255.
- `Clk`  in  1  clock; all logic on rising edge.
- `Reset_n`  in  1  reset; synchronous, active-low.
- `Req`  in  4  level request per requester i; held until that requester's `Rsp_valid[i]`.
- `Fp_bus`  in  64  requester i value at `[16i+15:16i]`; stable while `Req[i]`=1.
- `Rsp_valid`  out  4  one-hot, one-cycle response strobe to the granted requester.
- `Rsp_d1`  out  4  tenths digit (15 = out of range or error).
- `Rsp_d2`  out  4  hundredths digit, 0 or 5 (15 = out of range or error).
- `Rsp_err`  out  1  high with `Rsp_valid` when the response came from a timeout.
- `Busy`  out  1  high in every state except IDLE.
- `Dec_start`  out  1  Start to the decoder.
- `Dec_fp`  out  16  Fp_in to the decoder.
- `Dec_ack`  out  1  Ack to the decoder.
- `Dec_done`  in  1  Done from the decoder.
- `Dec_d1`, `Dec_d2`  in  4 each  Decode_1 and Decode_2 from the decoder.

## Operation
- All outputs and registers are registered. Reset values: state IDLE, all outputs 0, `Dec_fp`=0, timeout counter 0, `last_grant`=3, so requester 0 has first priority.
- **IDLE:** eligible = `Req` & ~mask. Mask is the one-hot of `last_grant` during the first IDLE cycle after REPLY, and 0 otherwise.
  - If any requester is eligible, pick the first one scanning `last_grant+1`, `+2`, `+3`, `+4` (mod 4).
  - Register grant g, load `Dec_fp` with the requester's Fp slice, set `Dec_start`=1, and go to ISSUE.
- **ISSUE (1 cycle):** `Dec_start`=1 with `Dec_fp` stable. Next state is WAIT. Clear `Dec_start` and the counter on exit.
- **WAIT:** `Dec_fp` is held and the counter increments each cycle.
  - If `Dec_done`=1: capture `Dec_d1`/`Dec_d2` into `Rsp_d1`/`Rsp_d2`, set `Rsp_err`=0, and go to REPLY.
  - Otherwise, if counter = `TIMEOUT`-1: set `Rsp_d1`=`Rsp_d2`=15, set `Rsp_err`=1, and go to REPLY.
  - `Dec_done` takes priority if both conditions hold in the same cycle.
- **REPLY (1 cycle):** `Rsp_valid[g]`=1 and `Dec_ack`=1. `last_grant` is set to g. Next state is IDLE with the mask armed. `Rsp_valid`, `Dec_ack` and `Rsp_err` return to 0 on exit.
- `Rsp_d1`/`Rsp_d2` hold their value until the next capture.
- `Req` is ignored outside IDLE. A requester that drops `Req` mid-transaction still receives its response.
- A synchronous reset in any state abandons the transaction: no `Rsp_valid` is issued, and every register returns to its reset value on the next edge.
- The digit values from the decoder are passed through unchanged. The block does not inspect `Fp_in`.

## Timing
- Grant is decided at the IDLE edge T. `Dec_start` is high during cycle T..T+1, and the decoder samples it at edge T+1.
- With the team decoder, `Dec_done` is first high after edge T+4 for in-range values and after T+3 for out-of-range values.
- Response: `Rsp_valid` is high during the cycle after edge T+5 (T+4 for out of range). `Dec_ack` is high in the same cycle and is sampled by the decoder at the next edge, which returns it to Init.
- Earliest next grant is edge T+6 (mask cycle), so the decoder is always back in Init before the next `Dec_start`.
- Timeout: REPLY follows exactly `TIMEOUT` WAIT cycles.
- Back-to-back throughput with all four requesting: one response per 7 cycles, in grant order 0,1,2,3,0,…

## Test plan
- `Req`=0001, Fp0=0x3A00 (0.75) -> `Rsp_valid`=0001 with d1=7, d2=5, err=0, 5 cycles after the grant edge; `Dec_start` one cycle wide; `Dec_ack` coincident with `Rsp_valid`.
- `Req`=1111 held, Fp0..3 = 0x3800, 0x3400, 0x3C00, 0x3A00 -> responses in order 0,1,2,3 with (5,0), (2,5), (15,15), (7,5); no requester served twice consecutively.
- Requester 2 still requesting after its response plus requester 0 requesting -> requester 0 granted next; requester 2 not re-granted in the mask cycle.
- Decoder model holds `Dec_done`=0, `TIMEOUT`=8 -> after 8 WAIT cycles `Rsp_valid[g]`=1, d1=d2=15, `Rsp_err`=1, `Dec_ack`=1.
- `Reset_n`=0 asserted for one cycle while in WAIT -> no `Rsp_valid`; next cycle all outputs 0, `Busy`=0, next grant goes to requester 0.
- `Dec_done` and timeout in the same cycle -> decoder digits returned with `Rsp_err`=0.
